// File: rtl/sha2_stream_periph.sv
// Word-serial SHA-224/256 peripheral: 16-bit DATA writes fill a 512-bit block,
// and an FSM issues init/next to an iterative one-round-per-cycle sha256_core.
module sha256_core (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic         mode,
    input  logic [511:0] block,
    output logic         ready,
    output logic [255:0] digest,
    output logic         digest_valid
);
    localparam logic [63:0][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [7:0][31:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [7:0][31:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [31:0]      h_q [8];
    logic [31:0]      v_q [8];
    logic [31:0]      w_q [16];
    logic [6:0]       rnd_q;
    logic             busy_q;
    logic             valid_q;
    logic [31:0]      t1, t2, w_new;
    logic [7:0][31:0] iv;

    always_comb begin
        iv    = mode ? IV256 : IV224;
        t1    = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
              + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[~rnd_q[5:0]] + w_q[0];
        t2    = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
              + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
              + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    end

    // w_q is a sliding 16-word window: w_q[0] is W[t] for the current round.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                h_q[i] <= '0;
                v_q[i] <= '0;
            end
            for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (!busy_q && (init || next)) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (init) h_q[i] <= iv[7-i];
                v_q[i] <= init ? iv[7-i] : h_q[i];
            end
            for (int unsigned i = 0; i < 16; i++) w_q[i] <= block[511-32*i -: 32];
            rnd_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else if (busy_q) begin
            if (rnd_q == 7'd64) begin
                for (int unsigned i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
            end else begin
                v_q[0] <= t1 + t2;
                v_q[1] <= v_q[0];
                v_q[2] <= v_q[1];
                v_q[3] <= v_q[2];
                v_q[4] <= v_q[3] + t1;
                v_q[5] <= v_q[4];
                v_q[6] <= v_q[5];
                v_q[7] <= v_q[6];
                for (int unsigned i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                w_q[15] <= w_new;
                rnd_q   <= rnd_q + 7'd1;
            end
        end
    end

    assign ready        = ~busy_q;
    assign digest_valid = valid_q;
    assign digest       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
endmodule

module sha2_stream_periph #(
    parameter logic [14:0] BASE_ADDR    = 15'h0080,
    parameter int unsigned DEC_WD       = 7,
    parameter int unsigned DIGEST_WORDS = 16
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq
);
    localparam logic [DEC_WD-1:0] OFF_CTRL   = DEC_WD'(8'h00);
    localparam logic [DEC_WD-1:0] OFF_STATUS = DEC_WD'(8'h02);
    localparam logic [DEC_WD-1:0] OFF_DATA   = DEC_WD'(8'h04);
    localparam logic [DEC_WD-1:0] OFF_WCNT   = DEC_WD'(8'h06);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_ISSUE, ST_WAIT} state_e;

    state_e             state_q, state_d;
    logic               mode_q, mode_d, irq_en_q, irq_en_d;
    logic               done_q, done_d, ovf_q, ovf_d;
    logic               first_q, first_d, skip_q, skip_d;
    logic [4:0]         wcnt_q, wcnt_d;
    logic [511:0]       block_q, block_d;
    logic               sel, wr_en, rd_en, start, data_wr, busy;
    logic [DEC_WD-1:0]  offset;
    logic               core_init, core_next, core_ready, core_valid;
    logic [255:0]       core_digest;

    assign sel     = per_en && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign offset  = {per_addr[DEC_WD-2:0], 1'b0};
    assign wr_en   = sel && (|per_we);
    assign rd_en   = sel && !(|per_we);
    assign start   = wr_en && (offset == OFF_CTRL) && per_din[0];
    assign data_wr = wr_en && (offset == OFF_DATA);
    assign busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign irq     = done_q & irq_en_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        first_d   = first_q;
        skip_d    = skip_q;
        wcnt_d    = wcnt_q;
        block_d   = block_q;
        core_init = 1'b0;
        core_next = 1'b0;
        if (wr_en && offset == OFF_CTRL) begin
            mode_d   = per_din[1];
            irq_en_d = per_din[2];
        end
        // W1C is applied first so a same-cycle completion below wins.
        if (wr_en && offset == OFF_STATUS) begin
            if (per_din[1]) done_d = 1'b0;
            if (per_din[2]) ovf_d  = 1'b0;
        end
        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (start) begin
                    state_d = ST_FILL;
                    wcnt_d  = '0;
                    first_d = 1'b1;
                    done_d  = 1'b0;
                end else if (data_wr && state_q == ST_IDLE) begin
                    ovf_d = 1'b1;
                end else if (data_wr) begin
                    for (int unsigned n = 0; n < 32; n++)
                        if (wcnt_q == 5'(n)) block_d[511-16*n -: 16] = per_din;
                    wcnt_d = wcnt_q + 5'd1;
                    if (wcnt_q == 5'd31) state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (start || data_wr) ovf_d = 1'b1;
                if (core_ready) begin
                    core_init = first_q;
                    core_next = ~first_q;
                    first_d   = 1'b0;
                    skip_d    = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (start || data_wr) ovf_d = 1'b1;
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (core_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            first_q  <= 1'b0;
            skip_q   <= 1'b0;
            wcnt_q   <= '0;
            block_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            first_q  <= first_d;
            skip_q   <= skip_d;
            wcnt_q   <= wcnt_d;
            block_q  <= block_d;
        end
    end

    always_comb begin
        per_dout = '0;
        if (rd_en) begin
            case (offset)
                OFF_CTRL:   per_dout = {13'b0, irq_en_q, mode_q, 1'b0};
                OFF_STATUS: per_dout = {11'b0, state_q == ST_FILL, core_valid, ovf_q, done_q, busy};
                OFF_WCNT:   per_dout = {11'b0, wcnt_q};
                default: begin
                    for (int unsigned k = 0; k < DIGEST_WORDS; k++)
                        if (offset == DEC_WD'(64 + 2*k)) per_dout = core_digest[255-16*k -: 16];
                end
            endcase
        end
    end

    sha256_core u_core (
        .clk          (mclk),
        .reset_n      (puc_rst_n),
        .init         (core_init),
        .next         (core_next),
        .mode         (mode_q),
        .block        (block_q),
        .ready        (core_ready),
        .digest       (core_digest),
        .digest_valid (core_valid)
    );
endmodule
